// File: rtl/sr_ctrl_debounce_pkg.sv
// Shared types and defaults for the SR latch command stage.
package sr_ctrl_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int PULSE_CYCLES_DEF    = 2;

    localparam int NUM_CH = 2;
    localparam int CH_SET = 0;
    localparam int CH_RST = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_e;

    typedef enum logic {
        SET,
        RESET
    } cmd_e;

    // Counter width that stays at least one bit for tiny counts.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sr_ctrl_debounce_if.sv
// Request/command bundle between the requester side and the latch command stage.
interface sr_ctrl_debounce_if;

    logic set_req;
    logic rst_req;
    logic s;
    logic r;
    logic en;
    logic busy;
    logic conflict;

    modport master (
        output set_req, rst_req,
        input  s, r, en, busy, conflict
    );

    modport slave (
        input  set_req, rst_req,
        output s, r, en, busy, conflict
    );

endinterface

// File: rtl/sr_ctrl_debounce_debounce.sv
// One request channel: 2-flop synchronizer, stability counter, rising-edge pulse.
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic rise_o
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          differ, flip;

    // Any cycle where the synchronized input agrees with the level restarts the count.
    always_comb begin
        differ  = sync_q[1] ^ level_q;
        flip    = differ && (cnt_q == CNT_MAX);
        cnt_d   = (differ && !flip) ? cnt_q + CW'(1) : '0;
        level_d = level_q ^ flip;
        rise_d  = flip & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sr_ctrl_debounce.sv
// Debounced set/reset requests turned into clean SETUP/PULSE/HOLD latch commands.
module sr_ctrl_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_ctrl_debounce_if.slave  bus
);

    localparam int              PCW      = cnt_w(PULSE_CYCLES);
    localparam logic [PCW-1:0]  PCNT_MAX = PCW'(PULSE_CYCLES - 1);

    logic [NUM_CH-1:0] raw, rise;
    logic [NUM_CH-1:0] pend_q, pend_d, pend_clr;
    state_e            state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic [PCW-1:0]    pcnt_q, pcnt_d;
    logic              s_c, r_c, en_c, busy_c, conflict_c;

    assign raw[CH_SET] = bus.set_req;
    assign raw[CH_RST] = bus.rst_req;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sr_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (raw[g]),
            .rise_o (rise[g])
        );
    end

    // A new edge wins over a same-cycle clear so it is never lost.
    assign pend_d = rise | (pend_q & ~pend_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cmd_q  <= SET;
            pcnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            cmd_q  <= cmd_d;
            pcnt_q <= pcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        pcnt_d   = pcnt_q;
        pend_clr = '0;
        unique case (state_q)
            IDLE: begin
                pcnt_d = '0;
                if (pend_q[CH_SET] && pend_q[CH_RST]) begin
                    pend_clr = '1;
                end else if (pend_q[CH_SET]) begin
                    state_d          = SETUP;
                    cmd_d            = SET;
                    pend_clr[CH_SET] = 1'b1;
                end else if (pend_q[CH_RST]) begin
                    state_d          = SETUP;
                    cmd_d            = RESET;
                    pend_clr[CH_RST] = 1'b1;
                end
            end
            SETUP: begin
                state_d = PULSE;
                pcnt_d  = '0;
            end
            PULSE: begin
                if (pcnt_q == PCNT_MAX) state_d = HOLD;
                else                    pcnt_d  = pcnt_q + PCW'(1);
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // s and r come from one command register, so they can never both be high.
    always_comb begin
        busy_c     = (state_q != IDLE);
        s_c        = busy_c && (cmd_q == SET);
        r_c        = busy_c && (cmd_q == RESET);
        en_c       = (state_q == PULSE);
        conflict_c = (state_q == IDLE) && pend_q[CH_SET] && pend_q[CH_RST];
    end

    assign bus.s        = s_c;
    assign bus.r        = r_c;
    assign bus.en       = en_c;
    assign bus.busy     = busy_c;
    assign bus.conflict = conflict_c;

endmodule

// File: tb/tb_sr_ctrl_debounce.sv
// Self-checking bench: window-based behavioural model plus directed scenarios.
module tb_sr_ctrl_debounce;

    localparam int DC = 4;
    localparam int P  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sr_ctrl_debounce_if bus ();

    sr_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .PULSE_CYCLES    (P)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: raw sample history per channel, newest in bit 0.
    bit [63:0] sh [2];
    bit        m_level [2];
    bit        m_rise  [2];
    bit        m_pend  [2];
    int        m_pos;          // -1 idle, else position 0..P+1 inside the command
    int        m_cmd;          // 0 set, 1 reset

    int ecnt = 0;
    int cnt_s = 0, cnt_r = 0, cnt_en = 0, cnt_busy = 0, cnt_conf = 0;
    int s_rise_edge = 0, r_rise_edge = 0, s_last_edge = 0;
    bit prev_s = 0, prev_r = 0;

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            sh[c]      = '0;
            m_level[c] = 0;
            m_rise[c]  = 0;
            m_pend[c]  = 0;
        end
        m_pos = -1;
        m_cmd = 0;
    endfunction

    function automatic void m_step(input bit raw0, input bit raw1);
        bit clr [2];
        bit all_diff;
        bit raw [2];
        raw[0] = raw0;
        raw[1] = raw1;
        clr[0] = 0;
        clr[1] = 0;
        if (m_pos < 0) begin
            if (m_pend[0] && m_pend[1]) begin
                clr[0] = 1; clr[1] = 1;
            end else if (m_pend[0]) begin
                m_pos = 0; m_cmd = 0; clr[0] = 1;
            end else if (m_pend[1]) begin
                m_pos = 0; m_cmd = 1; clr[1] = 1;
            end
        end else if (m_pos == P + 1) begin
            m_pos = -1;
        end else begin
            m_pos = m_pos + 1;
        end
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = m_rise[c] | (m_pend[c] & ~clr[c]);
            sh[c] = {sh[c][62:0], raw[c]};
            // Level follows once the last DC synchronized samples all disagree with it.
            all_diff = 1;
            for (int k = 0; k < DC; k++)
                if (sh[c][2 + k] == m_level[c]) all_diff = 0;
            m_rise[c] = all_diff && !m_level[c];
            if (all_diff) m_level[c] = ~m_level[c];
        end
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            ecnt++;
            if (rst_n) m_step(bus.set_req, bus.rst_req);
            else       m_reset();
            @(negedge clk);
            if (!rst_n) m_reset();
            chk("s",        int'(bus.s),        int'(m_pos >= 0 && m_cmd == 0));
            chk("r",        int'(bus.r),        int'(m_pos >= 0 && m_cmd == 1));
            chk("en",       int'(bus.en),       int'(m_pos >= 1 && m_pos <= P));
            chk("busy",     int'(bus.busy),     int'(m_pos >= 0));
            chk("conflict", int'(bus.conflict), int'(m_pos < 0 && m_pend[0] && m_pend[1]));
            chk("s_and_r",  int'(bus.s & bus.r), 0);
            if (bus.en)
                chk("en_stable", int'((bus.s ^ bus.r) && bus.s == prev_s && bus.r == prev_r), 1);
            if (bus.s) begin
                cnt_s++;
                s_last_edge = ecnt;
                if (!prev_s) s_rise_edge = ecnt;
            end
            if (bus.r) begin
                cnt_r++;
                if (!prev_r) r_rise_edge = ecnt;
            end
            if (bus.en)       cnt_en++;
            if (bus.busy)     cnt_busy++;
            if (bus.conflict) cnt_conf++;
            prev_s = bus.s;
            prev_r = bus.r;
        end
    end

    task automatic drive(input bit sv, input bit rv);
        @(posedge clk);
        #2;
        bus.set_req = sv;
        bus.rst_req = rv;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    int t0, b_s, b_r, b_en, b_busy, b_conf;

    task automatic snap();
        b_s = cnt_s; b_r = cnt_r; b_en = cnt_en; b_busy = cnt_busy; b_conf = cnt_conf;
    endtask

    initial begin
        bus.set_req = 0;
        bus.rst_req = 0;
        rst_n = 0;
        wait_cyc(3);
        #2;
        chk("rst_s",        int'(bus.s), 0);
        chk("rst_r",        int'(bus.r), 0);
        chk("rst_en",       int'(bus.en), 0);
        chk("rst_busy",     int'(bus.busy), 0);
        chk("rst_conflict", int'(bus.conflict), 0);
        rst_n = 1;
        wait_cyc(5);

        // Clean set
        snap();
        drive(1, 0);
        t0 = ecnt;
        wait_cyc(20);
        chk("clean_s_cycles",    cnt_s - b_s, 4);
        chk("clean_en_cycles",   cnt_en - b_en, 2);
        chk("clean_r_cycles",    cnt_r - b_r, 0);
        chk("clean_busy_cycles", cnt_busy - b_busy, 4);
        chk("clean_latency",     s_rise_edge - t0, 8);
        drive(0, 0);
        wait_cyc(20);

        // Bounce rejection
        snap();
        for (int i = 0; i < 12; i++) drive(((i / 2) % 2) == 0, 0);
        chk("bounce_no_cmd", cnt_s - b_s, 0);
        drive(1, 0);
        wait_cyc(20);
        chk("bounce_s_cycles",  cnt_s - b_s, 4);
        chk("bounce_en_cycles", cnt_en - b_en, 2);
        chk("bounce_conflict",  cnt_conf - b_conf, 0);
        drive(0, 0);
        wait_cyc(20);

        // Collision
        snap();
        drive(1, 1);
        wait_cyc(20);
        chk("coll_conflict", cnt_conf - b_conf, 1);
        chk("coll_s",        cnt_s - b_s, 0);
        chk("coll_r",        cnt_r - b_r, 0);
        chk("coll_en",       cnt_en - b_en, 0);
        drive(0, 0);
        wait_cyc(20);

        // Reset edge lands while SET is in PULSE
        snap();
        drive(1, 0);
        t0 = ecnt;
        wait_cyc(2);
        drive(1, 1);
        wait_cyc(25);
        chk("queue_s_cycles",  cnt_s - b_s, 4);
        chk("queue_r_cycles",  cnt_r - b_r, 4);
        chk("queue_en_cycles", cnt_en - b_en, 4);
        chk("queue_busy",      cnt_busy - b_busy, 8);
        chk("queue_conflict",  cnt_conf - b_conf, 0);
        chk("queue_r_start",   r_rise_edge - t0, 13);
        chk("queue_idle_gap",  r_rise_edge - s_last_edge, 2);
        drive(0, 0);
        wait_cyc(20);

        // Mid-command reset
        drive(1, 0);
        wait_cyc(9);
        #2;
        chk("mid_en_before", int'(bus.en), 1);
        rst_n = 0;
        bus.set_req = 0;
        #1;
        chk("mid_s",    int'(bus.s), 0);
        chk("mid_en",   int'(bus.en), 0);
        chk("mid_busy", int'(bus.busy), 0);
        wait_cyc(3);
        #2;
        rst_n = 1;
        snap();
        wait_cyc(30);
        chk("mid_after_s",  cnt_s - b_s, 0);
        chk("mid_after_r",  cnt_r - b_r, 0);
        chk("mid_after_en", cnt_en - b_en, 0);

        // Random bouncing on both lines, checked against the model every cycle
        for (int seg = 0; seg < 400; seg++) begin
            bit sv, rv;
            int len;
            sv  = 1'($urandom_range(0, 1));
            rv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            drive(sv, rv);
            wait_cyc(len - 1);
        end
        drive(0, 0);
        wait_cyc(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
